rs_wakeup_array: RTL

RS_WAKEUP_ARRAY -- requirements
Module: rs_wakeup_array

---
 rtl/rs_wakeup_array_pkg.sv | 23 ++
 rtl/rs_wakeup_picker.sv | 62 ++++++
 rtl/rs_wakeup_array.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rs_wakeup_array_pkg.sv
`default_nettype none
// =====================================================================
// rs_wakeup_array_pkg -- shared op-type codes and default widths
// Rev 1.0
// =====================================================================
package rs_wakeup_array_pkg;

  localparam int RS_ROB_BIT = 4;
  localparam int XLEN       = 32;
  localparam int OP_TYPE_W  = 7;

  localparam logic [OP_TYPE_W-1:0] R_TYPE      = 7'b0110011;
  localparam logic [OP_TYPE_W-1:0] ALGI_TYPE   = 7'b0010011;
  localparam logic [OP_TYPE_W-1:0] LOAD_TYPE   = 7'b0000011;
  localparam logic [OP_TYPE_W-1:0] STORE_TYPE  = 7'b0100011;
  localparam logic [OP_TYPE_W-1:0] BRANCH_TYPE = 7'b1100011;
  localparam logic [OP_TYPE_W-1:0] JAL_TYPE    = 7'b1101111;
  localparam logic [OP_TYPE_W-1:0] JALR_TYPE   = 7'b1100111;
  localparam logic [OP_TYPE_W-1:0] LUI_TYPE    = 7'b0110111;
  localparam logic [OP_TYPE_W-1:0] AUIPC_TYPE  = 7'b0010111;

endpackage
`default_nettype wire

// File: rtl/rs_wakeup_picker.sv
`default_nettype none
// =====================================================================
// rs_wakeup_picker -- lowest free slot and dispatch pick (oldest eligible
// when RS_AGE_ORDER_EN is defined, else lowest index).  Rev 1.0
// =====================================================================
module rs_wakeup_picker #(
  parameter int RS_DEPTH = 8
) (
  input  logic [RS_DEPTH-1:0]                  busy,
  input  logic [RS_DEPTH-1:0]                  eligible,
`ifdef RS_AGE_ORDER_EN
  input  logic [RS_DEPTH*$clog2(RS_DEPTH)-1:0] rank_flat,
`endif
  output logic                                 free_found,
  output logic [$clog2(RS_DEPTH)-1:0]          free_idx,
  output logic                                 elig_found,
  output logic [$clog2(RS_DEPTH)-1:0]          elig_idx
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Rank counts older busy entries, so the smallest rank is the oldest.
  logic [IDX_W-1:0] best_rank;
  always_comb begin
    elig_found = 1'b0;
    elig_idx   = '0;
    best_rank  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (eligible[i] && (!elig_found || rank_flat[i*IDX_W +: IDX_W] < best_rank)) begin
        elig_found = 1'b1;
        elig_idx   = IDX_W'(i);
        best_rank  = rank_flat[i*IDX_W +: IDX_W];
      end
    end
  end
`else
  always_comb begin
    elig_found = 1'b0;
    elig_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (eligible[i] && !elig_found) begin
        elig_found = 1'b1;
        elig_idx   = IDX_W'(i);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/rs_wakeup_array.sv
`default_nettype none
// =====================================================================
// rs_wakeup_array -- reservation station with CDB wakeup and a single
// skid-free dispatch register; RS_AGE_ORDER_EN selects oldest-first.  Rev 1.0
// =====================================================================
module rs_wakeup_array
  import rs_wakeup_array_pkg::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int ROB_BIT  = RS_ROB_BIT,
  parameter int CDB_N    = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          rob_clear_up,
  input  logic                          issue_valid,
  input  logic [OP_TYPE_W-1:0]          op_type_in,
  input  logic [2:0]                    op_in,
  input  logic                          op_add_in,
  input  logic [XLEN-1:0]               v1_in,
  input  logic [XLEN-1:0]               v2_in,
  input  logic                          dep1_in,
  input  logic                          dep2_in,
  input  logic [ROB_BIT-1:0]            tag1_in,
  input  logic [ROB_BIT-1:0]            tag2_in,
  input  logic [ROB_BIT-1:0]            rd_rob_in,
  input  logic [CDB_N-1:0]              cdb_valid,
  input  logic [CDB_N*ROB_BIT-1:0]      cdb_tag,
  input  logic [CDB_N*XLEN-1:0]         cdb_value,
  output logic                          disp_valid,
  input  logic                          disp_ready,
  output logic [OP_TYPE_W-1:0]          disp_op_type,
  output logic [2:0]                    disp_op,
  output logic                          disp_op_add,
  output logic [XLEN-1:0]               disp_v1,
  output logic [XLEN-1:0]               disp_v2,
  output logic [ROB_BIT-1:0]            disp_rob,
  output logic                          rs_full,
  output logic [$clog2(RS_DEPTH):0]     rs_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_DEPTH-1:0]  busy, dep1, dep2, eligible;
  logic [OP_TYPE_W-1:0] ent_op_type [RS_DEPTH];
  logic [2:0]           ent_op      [RS_DEPTH];
  logic                 ent_op_add  [RS_DEPTH];
  logic [XLEN-1:0]      ent_v1      [RS_DEPTH];
  logic [XLEN-1:0]      ent_v2      [RS_DEPTH];
  logic [ROB_BIT-1:0]   ent_tag1    [RS_DEPTH];
  logic [ROB_BIT-1:0]   ent_tag2    [RS_DEPTH];
  logic [ROB_BIT-1:0]   ent_rob     [RS_DEPTH];

  logic [XLEN:0]        wake1 [RS_DEPTH];
  logic [XLEN:0]        wake2 [RS_DEPTH];
  logic [XLEN:0]        byp1, byp2;
  logic                 free_found, elig_found, do_issue, load;
  logic [IDX_W-1:0]     free_idx, elig_idx;
  logic [CNT_W-1:0]     busy_cnt;

  // Returns {hit, value}; scanning high to low lets channel 0 win ties.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ROB_BIT-1:0]       tag,
    input logic [CDB_N-1:0]         vld,
    input logic [CDB_N*ROB_BIT-1:0] tags,
    input logic [CDB_N*XLEN-1:0]    vals
  );
    logic [XLEN:0] res;
    res = '0;
    for (int k = CDB_N - 1; k >= 0; k--) begin
      if (vld[k] && tags[k*ROB_BIT +: ROB_BIT] == tag) res = {1'b1, vals[k*XLEN +: XLEN]};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      wake1[i] = cdb_lookup(ent_tag1[i], cdb_valid, cdb_tag, cdb_value);
      wake2[i] = cdb_lookup(ent_tag2[i], cdb_valid, cdb_tag, cdb_value);
    end
    byp1 = cdb_lookup(tag1_in, cdb_valid, cdb_tag, cdb_value);
    byp2 = cdb_lookup(tag2_in, cdb_valid, cdb_tag, cdb_value);
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) busy_cnt = busy_cnt + CNT_W'(busy[i]);
  end

  assign eligible = busy & ~dep1 & ~dep2;
  assign rs_count = busy_cnt;
  assign rs_full  = &busy;
  assign do_issue = issue_valid && free_found;
  assign load     = (!disp_valid || disp_ready) && elig_found;

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0]          ent_rank [RS_DEPTH];
  logic [IDX_W-1:0]          new_rank;
  logic [RS_DEPTH*IDX_W-1:0] rank_flat;

  // A new entry is younger than every entry that survives this edge.
  always_comb begin
    new_rank = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (busy[i] && !(load && elig_idx == IDX_W'(i))) new_rank = new_rank + IDX_W'(1);
    end
  end

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_rank
    assign rank_flat[g*IDX_W +: IDX_W] = ent_rank[g];
  end
`endif

  rs_wakeup_picker #(.RS_DEPTH(RS_DEPTH)) u_picker (
    .busy       (busy),
    .eligible   (eligible),
`ifdef RS_AGE_ORDER_EN
    .rank_flat  (rank_flat),
`endif
    .free_found (free_found),
    .free_idx   (free_idx),
    .elig_found (elig_found),
    .elig_idx   (elig_idx)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && rob_clear_up)) begin
      busy         <= '0;
      dep1         <= '0;
      dep2         <= '0;
      disp_valid   <= 1'b0;
      disp_op_type <= '0;
      disp_op      <= '0;
      disp_op_add  <= 1'b0;
      disp_v1      <= '0;
      disp_v2      <= '0;
      disp_rob     <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy[i] && dep1[i] && wake1[i][XLEN]) begin
          dep1[i]   <= 1'b0;
          ent_v1[i] <= wake1[i][XLEN-1:0];
        end
        if (busy[i] && dep2[i] && wake2[i][XLEN]) begin
          dep2[i]   <= 1'b0;
          ent_v2[i] <= wake2[i][XLEN-1:0];
        end
      end
      if (do_issue) begin
        busy[free_idx]        <= 1'b1;
        ent_op_type[free_idx] <= op_type_in;
        ent_op[free_idx]      <= op_in;
        ent_op_add[free_idx]  <= op_add_in;
        ent_rob[free_idx]     <= rd_rob_in;
        ent_tag1[free_idx]    <= tag1_in;
        ent_tag2[free_idx]    <= tag2_in;
        dep1[free_idx]        <= dep1_in && !byp1[XLEN];
        dep2[free_idx]        <= dep2_in && !byp2[XLEN];
        ent_v1[free_idx]      <= (dep1_in && byp1[XLEN]) ? byp1[XLEN-1:0] : v1_in;
        ent_v2[free_idx]      <= (dep2_in && byp2[XLEN]) ? byp2[XLEN-1:0] : v2_in;
      end
      if (load) begin
        busy[elig_idx] <= 1'b0;
        disp_valid     <= 1'b1;
        disp_op_type   <= ent_op_type[elig_idx];
        disp_op        <= ent_op[elig_idx];
        disp_op_add    <= ent_op_add[elig_idx];
        disp_v1        <= ent_v1[elig_idx];
        disp_v2        <= ent_v2[elig_idx];
        disp_rob       <= ent_rob[elig_idx];
      end else if (disp_ready) begin
        disp_valid <= 1'b0;
      end
`ifdef RS_AGE_ORDER_EN
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (load && busy[i] && ent_rank[i] > ent_rank[elig_idx]) ent_rank[i] <= ent_rank[i] - IDX_W'(1);
      end
      if (do_issue) ent_rank[free_idx] <= new_rank;
`endif
    end
  end

endmodule
`default_nettype wire
